// File: rtl/binary_maxpool_flatten.sv
// binary_maxpool_flatten
//   Takes a binarised IMG_H x IMG_W feature map one row per handshake, applies a
//   2x2 binary max-pool (a 4-input OR) and flattens the result into an OUT_BITS
//   vector for the final dense layer. The block is active only while the global
//   sequencer state equals S_POOL.
// Ports
//   clock      system clock, all logic on posedge
//   reset      synchronous, active-high
//   state      global layer-sequencer state
//   row_in     one feature-map row, bit c = column c
//   row_valid  row_in holds a valid row
//   row_ready  block accepts row_in this cycle (registered)
//   data_out   pooled map, bit r*(IMG_W/2)+c = pool cell (r,c)
//   pool_done  data_out complete and stable (registered)

// One pool cell: OR of a 2x2 window (two bits from the buffered even row and two
// bits from the odd row currently on the input).
module binary_maxpool_cell (
    input  logic [1:0] top,
    input  logic [1:0] bot,
    output logic       pooled
);
    assign pooled = |{top, bot};
endmodule

module binary_maxpool_flatten #(
    parameter int          IMG_W    = 28,
    parameter int          IMG_H    = 28,
    parameter logic [2:0]  S_POOL   = 3'b011,
    localparam int         OUT_BITS = (IMG_W / 2) * (IMG_H / 2)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [2:0]          state,
    input  logic [IMG_W-1:0]    row_in,
    input  logic                row_valid,
    output logic                row_ready,
    output logic [OUT_BITS-1:0] data_out,
    output logic                pool_done
);
    localparam int POOL_W = IMG_W / 2;
    localparam int CNT_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {IDLE, EVEN, ODD, DONE} fsm_t;

    fsm_t              fsm, fsm_nxt;
    logic [CNT_W-1:0]  row_cnt;
    logic [IMG_W-1:0]  row_buf;
    logic [POOL_W-1:0] pooled_row;

    logic accept, last_row, clear_out, load_buf, write_pool, abort;
    int unsigned base;

    genvar c;
    generate
        for (c = 0; c < POOL_W; c++) begin : g_cell
            binary_maxpool_cell u_cell (
                .top    (row_buf[2*c +: 2]),
                .bot    (row_in[2*c +: 2]),
                .pooled (pooled_row[c])
            );
        end
    endgenerate

    assign accept   = row_valid && row_ready;
    assign last_row = (row_cnt == CNT_W'(IMG_H - 1));

    always_comb begin
        fsm_nxt    = fsm;
        clear_out  = 1'b0;
        load_buf   = 1'b0;
        write_pool = 1'b0;
        abort      = 1'b0;
        // Each even/odd row pair lands in pool row row_cnt>>1.
        base       = int'(row_cnt >> 1) * POOL_W;
        case (fsm)
            IDLE: begin
                if (state == S_POOL) begin
                    fsm_nxt   = EVEN;
                    clear_out = 1'b1;
                end
            end
            EVEN: begin
                // Leaving S_POOL wins over a simultaneous handshake.
                if (state != S_POOL) begin
                    fsm_nxt = IDLE;
                    abort   = 1'b1;
                end else if (accept) begin
                    fsm_nxt  = ODD;
                    load_buf = 1'b1;
                end
            end
            ODD: begin
                if (state != S_POOL) begin
                    fsm_nxt = IDLE;
                    abort   = 1'b1;
                end else if (accept) begin
                    fsm_nxt    = last_row ? DONE : EVEN;
                    write_pool = 1'b1;
                end
            end
            DONE: begin
                if (state != S_POOL) fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm       <= IDLE;
            row_cnt   <= '0;
            row_buf   <= '0;
            data_out  <= '0;
            row_ready <= 1'b0;
            pool_done <= 1'b0;
        end else begin
            fsm       <= fsm_nxt;
            // Flags are decoded from the next state so they come straight off flops.
            row_ready <= (fsm_nxt == EVEN) || (fsm_nxt == ODD);
            pool_done <= (fsm_nxt == DONE);
            if (clear_out) data_out <= '0;
            if (abort) begin
                row_cnt <= '0;
                row_buf <= '0;
            end
            if (load_buf) begin
                row_buf <= row_in;
                row_cnt <= row_cnt + CNT_W'(1);
            end
            if (write_pool) begin
                data_out[base +: POOL_W] <= pooled_row;
                row_cnt <= last_row ? '0 : row_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_binary_maxpool_flatten.sv
module tb_binary_maxpool_flatten;
    localparam int         IMG_W    = 28;
    localparam int         IMG_H    = 28;
    localparam int         HW       = IMG_W / 2;
    localparam int         OUT_BITS = (IMG_W / 2) * (IMG_H / 2);
    localparam logic [2:0] S_POOL   = 3'b011;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [2:0]          state = 3'b000;
    logic [IMG_W-1:0]    row_in = '0;
    logic                row_valid = 1'b0;
    logic                row_ready;
    logic                pool_done;
    logic [OUT_BITS-1:0] data_out;

    logic [IMG_W-1:0]    img [IMG_H];
    logic [OUT_BITS-1:0] bit31;
    int n_cmp = 0;
    int n_bad = 0;
    int idx;
    int cycles;
    bit both_high;

    binary_maxpool_flatten #(.IMG_W(IMG_W), .IMG_H(IMG_H), .S_POOL(S_POOL)) dut (
        .clock     (clock),
        .reset     (reset),
        .state     (state),
        .row_in    (row_in),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .data_out  (data_out),
        .pool_done (pool_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [OUT_BITS-1:0] got,
                       input logic [OUT_BITS-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Pooled vector for the first nrows rows of img; incomplete pool rows stay 0.
    function automatic logic [OUT_BITS-1:0] model(input int nrows);
        logic [OUT_BITS-1:0] v = '0;
        for (int r = 0; r < nrows / 2; r++)
            for (int c = 0; c < HW; c++)
                v[r*HW + c] = img[2*r][2*c] | img[2*r][2*c+1] |
                              img[2*r+1][2*c] | img[2*r+1][2*c+1];
        return v;
    endfunction

    task automatic fill_random();
        for (int r = 0; r < IMG_H; r++)
            img[r] = IMG_W'($urandom & $urandom & $urandom);
    endtask

    // One complete pass; exp_cycles > 0 also checks the edge count to pool_done.
    task automatic do_pass(input bit rand_valid, input int exp_cycles, input string tag);
        logic rdy;
        idx = 0;
        cycles = 0;
        both_high = 1'b0;
        state = S_POOL;
        while (cycles < 500) begin
            if (idx < IMG_H) row_in = img[idx];
            else row_in = IMG_W'($urandom);
            row_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            rdy = row_ready;
            @(posedge clock);
            cycles++;
            if (rdy && row_valid) idx++;
            #1;
            if (row_ready && pool_done) both_high = 1'b1;
            if (pool_done) break;
        end
        chk({tag, "_done_reached"}, OUT_BITS'(pool_done), OUT_BITS'(1));
        chk({tag, "_accepts"}, OUT_BITS'(idx), OUT_BITS'(IMG_H));
        if (exp_cycles > 0) chk({tag, "_latency"}, OUT_BITS'(cycles), OUT_BITS'(exp_cycles));
        chk({tag, "_data"}, data_out, model(IMG_H));
        // Rows offered in DONE must be ignored.
        row_valid = 1'b1;
        row_in = '1;
        repeat (3) @(posedge clock);
        #1;
        if (row_ready && pool_done) both_high = 1'b1;
        chk({tag, "_done_flags"}, OUT_BITS'({row_ready, pool_done}), OUT_BITS'(2'b01));
        chk({tag, "_done_hold"}, data_out, model(IMG_H));
        state = 3'b000;
        @(posedge clock);
        #1;
        chk({tag, "_exit_flags"}, OUT_BITS'({row_ready, pool_done}), OUT_BITS'(0));
        repeat (3) @(posedge clock);
        #1;
        chk({tag, "_idle_hold"}, data_out, model(IMG_H));
        chk({tag, "_never_both"}, OUT_BITS'(both_high), OUT_BITS'(0));
        row_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("reset_data", data_out, '0);
        chk("reset_flags", OUT_BITS'({row_ready, pool_done}), OUT_BITS'(0));
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Reset asserted for 2 cycles in the middle of a pass
        for (int r = 0; r < IMG_H; r++) img[r] = '1;
        state = S_POOL;
        row_valid = 1'b1;
        row_in = '1;
        repeat (6) @(posedge clock);
        #1;
        chk("midpass_partial", data_out, model(4));
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("midreset_data", data_out, '0);
        chk("midreset_flags", OUT_BITS'({row_ready, pool_done}), OUT_BITS'(0));
        state = 3'b000;
        row_valid = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("postreset_idle", OUT_BITS'({row_ready, pool_done}), OUT_BITS'(0));

        // Checkerboard -> every pool cell set
        for (int r = 0; r < IMG_H; r++) img[r] = (r % 2 == 1) ? 28'hAAAAAAA : 28'h5555555;
        do_pass(1'b0, 0, "checker");
        chk("checker_all_ones", data_out, '1);

        // Single pixel (row 5, col 7) -> only bit 31; also proves the clear on re-entry
        for (int r = 0; r < IMG_H; r++) img[r] = '0;
        img[5][7] = 1'b1;
        do_pass(1'b0, 0, "pixel");
        bit31 = '0;
        bit31[31] = 1'b1;
        chk("pixel_bit31", data_out, bit31);

        // All-zero map, back-to-back rows. pool_done appears in the 30th cycle counted
        // from the one in which S_POOL is presented, i.e. after 29 rising edges.
        for (int r = 0; r < IMG_H; r++) img[r] = '0;
        do_pass(1'b0, 29, "zero");

        // Random map, random row_valid
        for (int k = 0; k < 3; k++) begin
            fill_random();
            do_pass(1'b1, 0, "random");
        end

        // Abort after 9 rows
        fill_random();
        idx = 0;
        cycles = 0;
        state = S_POOL;
        row_valid = 1'b1;
        while (idx < 9 && cycles < 100) begin
            logic rdy;
            row_in = img[idx];
            rdy = row_ready;
            @(posedge clock);
            cycles++;
            if (rdy) idx++;
            #1;
        end
        chk("abort_rows_fed", OUT_BITS'(idx), OUT_BITS'(9));
        state = 3'b100;
        row_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("abort_flags", OUT_BITS'({row_ready, pool_done}), OUT_BITS'(0));
        chk("abort_partial", data_out, model(9));
        row_valid = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        chk("abort_stays_idle", OUT_BITS'({row_ready, pool_done}), OUT_BITS'(0));
        chk("abort_partial_hold", data_out, model(9));
        row_valid = 1'b0;
        state = 3'b000;
        fill_random();
        do_pass(1'b1, 0, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
